// File: rtl/cell_write_ctrl_p.sv
// Cell writer: packs ingress beats into fixed-size cells, appends a link footer and
// writes one free-list block per cell, reporting head block and cell count per frame.
module cell_write_ctrl_p #(
  parameter int DATA_W     = 64,
  parameter int CELL_BEATS = 7,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 8,
  parameter int BLOCK_W    = CELL_BEATS*DATA_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  input  logic               in_sop_i,
  input  logic               in_eop_i,
  output logic               in_ready_o,
  output logic               fl_alloc_req_o,
  input  logic               fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]  fl_alloc_idx_i,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  output logic               frm_done_o,
  output logic [ADDR_W-1:0]  frm_head_idx_o,
  output logic [CNT_W-1:0]   frm_cells_o,
  output logic               err_o
);

  localparam int BC_W  = $clog2(CELL_BEATS+1);
  localparam int PAY_W = CELL_BEATS*DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] beat_q [CELL_BEATS];
  logic [BC_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]  cells_q;
  logic [ADDR_W-1:0] head_q, curr_idx_q, next_idx_q;
  logic              curr_v_q, next_v_q, sop_pend_q, eop_q, done_q, err_q;

  logic              acc_s, gnt_s, gnt_err_s, curr_v_s, next_v_s;
  logic              close_s, blk_ok_s, wait_ok_s;
  logic [PAY_W-1:0]  pay_s;
  logic [DATA_W-1:0] foot_s;

  // Handshake qualifiers; slot validity includes a grant landing this cycle
  always_comb begin
    acc_s     = in_valid_i & in_ready_o;
    gnt_s     = fl_alloc_gnt_i & fl_alloc_req_o;
    gnt_err_s = fl_alloc_gnt_i & ~rst & curr_v_q & next_v_q;
    curr_v_s  = curr_v_q | gnt_s;
    next_v_s  = next_v_q | (gnt_s & curr_v_q);
    close_s   = 1'b0;
    if (acc_s && state_q == S_IDLE) begin
      close_s = in_sop_i & in_eop_i;
    end else if (acc_s && state_q == S_FILL) begin
      close_s = in_eop_i | (beat_cnt_q == BC_W'(CELL_BEATS-1));
    end else begin
      close_s = 1'b0;
    end
    blk_ok_s  = curr_v_s & (in_eop_i | next_v_s);
    wait_ok_s = curr_v_s & (eop_q | next_v_s);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (acc_s && in_sop_i) begin
          state_d = !close_s ? S_FILL : (blk_ok_s ? S_WRITE : S_WAIT);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (close_s) begin
          state_d = blk_ok_s ? S_WRITE : S_WAIT;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WAIT: begin
        if (wait_ok_s) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WRITE: state_d = eop_q ? S_IDLE : S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything forced low while in reset
  always_comb begin
    pay_s = '0;
    for (int i = 0; i < CELL_BEATS; i++) begin
      pay_s[PAY_W-1-i*DATA_W -: DATA_W] = beat_q[i];
    end
    foot_s                    = '0;
    foot_s[ADDR_W-1:0]        = eop_q ? '0 : next_idx_q;
    foot_s[ADDR_W]            = eop_q;
    foot_s[ADDR_W+1]          = 1'b1;
    foot_s[ADDR_W+2 +: BC_W]  = beat_cnt_q;
    in_ready_o     = ~rst & ((state_q == S_IDLE) | (state_q == S_FILL));
    mem_we_o       = ~rst & (state_q == S_WRITE);
    mem_addr_o     = mem_we_o ? curr_idx_q : '0;
    mem_wdata_o    = mem_we_o ? {pay_s, foot_s} : '0;
    fl_alloc_req_o = ~rst & (~curr_v_q | ~next_v_q);
    frm_done_o     = ~rst & done_q;
    frm_head_idx_o = rst ? '0 : head_q;
    frm_cells_o    = rst ? '0 : cells_q;
    err_o          = ~rst & err_q;
  end

  // Datapath: block slots, beat buffer, frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELL_BEATS; i++) begin
        beat_q[i] <= '0;
      end
      beat_cnt_q <= '0;
      cells_q    <= '0;
      head_q     <= '0;
      curr_idx_q <= '0;
      next_idx_q <= '0;
      curr_v_q   <= 1'b0;
      next_v_q   <= 1'b0;
      sop_pend_q <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= gnt_err_s
              | (acc_s & in_sop_i & (state_q == S_FILL))
              | (acc_s & ~in_sop_i & (state_q == S_IDLE));
      // On a write the next block shifts into curr; a grant refills whichever slot is empty
      if (state_q == S_WRITE) begin
        curr_idx_q <= next_idx_q;
        curr_v_q   <= next_v_q;
        next_v_q   <= 1'b0;
        if (gnt_s) begin
          if (next_v_q) begin
            next_idx_q <= fl_alloc_idx_i;
            next_v_q   <= 1'b1;
          end else begin
            curr_idx_q <= fl_alloc_idx_i;
            curr_v_q   <= 1'b1;
          end
        end
      end else if (gnt_s) begin
        if (!curr_v_q) begin
          curr_idx_q <= fl_alloc_idx_i;
          curr_v_q   <= 1'b1;
        end else begin
          next_idx_q <= fl_alloc_idx_i;
          next_v_q   <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (acc_s && in_sop_i) begin
            beat_q[0]  <= in_data_i;
            beat_cnt_q <= BC_W'(1);
            cells_q    <= '0;
            sop_pend_q <= 1'b1;
            eop_q      <= in_eop_i;
          end
        end
        S_FILL: begin
          if (acc_s) begin
            for (int i = 0; i < CELL_BEATS; i++) begin
              if (beat_cnt_q == BC_W'(i)) begin
                beat_q[i] <= in_data_i;
              end
            end
            beat_cnt_q <= beat_cnt_q + 1'b1;
            eop_q      <= in_eop_i;
          end
        end
        S_WRITE: begin
          for (int i = 0; i < CELL_BEATS; i++) begin
            beat_q[i] <= '0;
          end
          beat_cnt_q <= '0;
          eop_q      <= 1'b0;
          done_q     <= eop_q;
          if (sop_pend_q) begin
            head_q     <= curr_idx_q;
            sop_pend_q <= 1'b0;
          end
          if (cells_q != '1) begin
            cells_q <= cells_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_write_ctrl_p.sv
// Directed bench for cell_write_ctrl_p: multi-cell frames, block prefetch, stalls,
// protocol errors and reset mid-cell, with hand-computed blocks and footers.
module tb_cell_write_ctrl_p;
  localparam int DATA_W = 64, CELL_BEATS = 7, ADDR_W = 10, CNT_W = 8;
  localparam int BLOCK_W = CELL_BEATS*DATA_W + DATA_W;

  logic clk = 1'b0;
  logic rst;
  logic [DATA_W-1:0]  in_data_i;
  logic in_valid_i, in_sop_i, in_eop_i, in_ready_o;
  logic fl_alloc_req_o, fl_alloc_gnt_i;
  logic [ADDR_W-1:0]  fl_alloc_idx_i;
  logic mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [BLOCK_W-1:0] mem_wdata_o;
  logic frm_done_o;
  logic [ADDR_W-1:0]  frm_head_idx_o;
  logic [CNT_W-1:0]   frm_cells_o;
  logic err_o;

  int n_vec = 0, n_bad = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;

  always #5 clk = ~clk;

  cell_write_ctrl_p #(.DATA_W(DATA_W), .CELL_BEATS(CELL_BEATS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_sop_i(in_sop_i), .in_eop_i(in_eop_i),
    .in_ready_o(in_ready_o),
    .fl_alloc_req_o(fl_alloc_req_o), .fl_alloc_gnt_i(fl_alloc_gnt_i), .fl_alloc_idx_i(fl_alloc_idx_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .frm_done_o(frm_done_o), .frm_head_idx_o(frm_head_idx_o), .frm_cells_o(frm_cells_o),
    .err_o(err_o)
  );

  // Pulse counters sampled just before each active edge
  always @(posedge clk) begin
    if (mem_we_o)   wr_cnt++;
    if (frm_done_o) done_cnt++;
    if (err_o)      err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Expected block: beats base+first.. (n of them) from the MSB down, zeros after, footer in LSBs
  function automatic logic [BLOCK_W-1:0] blk(input logic [63:0] base, input int first,
                                             input int n, input logic [63:0] foot);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < CELL_BEATS; i++)
      if (i < n) r[BLOCK_W-1-i*64 -: 64] = base + 64'(first + i);
    r[63:0] = foot;
    return r;
  endfunction

  task automatic send(input logic [63:0] d, input logic s, input logic e);
    int n;
    n = 0;
    in_valid_i = 1'b1; in_data_i = d; in_sop_i = s; in_eop_i = e;
    while (in_ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= 40) begin
      $display("FAIL send_timeout: ready never rose for beat %h", d);
      n_bad++;
    end
    @(negedge clk);
    in_valid_i = 1'b0; in_sop_i = 1'b0; in_eop_i = 1'b0;
  endtask

  task automatic grant(input logic [9:0] idx);
    fl_alloc_gnt_i = 1'b1;
    fl_alloc_idx_i = idx;
    @(negedge clk);
    fl_alloc_gnt_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({in_ready_o, fl_alloc_req_o, mem_we_o, frm_done_o, err_o} !== 5'b00000) begin
      $display("FAIL reset_ctrl: got %b want 00000", {in_ready_o, fl_alloc_req_o, mem_we_o, frm_done_o, err_o});
      n_bad++;
    end
    n_vec++;
    if (mem_addr_o !== 10'd0 || mem_wdata_o !== '0 || frm_head_idx_o !== 10'd0 || frm_cells_o !== 8'd0) begin
      $display("FAIL reset_data: addr=%0d head=%0d cells=%0d want zeros", mem_addr_o, frm_head_idx_o, frm_cells_o);
      n_bad++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready_o, fl_alloc_req_o} !== 2'b11) begin
      $display("FAIL reset_release: ready/req=%b want 11", {in_ready_o, fl_alloc_req_o});
      n_bad++;
    end
  endtask

  task automatic test_two_cell_frame;
    logic [63:0] b;
    b = 64'hA100_0000_0000_0000;
    grant(10'd5);
    grant(10'd9);
    n_vec++;
    if (fl_alloc_req_o !== 1'b0) begin
      $display("FAIL req_full: req=%b want 0", fl_alloc_req_o); n_bad++;
    end
    grant(10'd12);
    n_vec++;
    if (err_o !== 1'b1) begin
      $display("FAIL gnt_overflow_err: err=%b want 1", err_o); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (err_o !== 1'b0) begin
      $display("FAIL gnt_err_pulse: err=%b want 0", err_o); n_bad++;
    end
    for (int k = 0; k < 7; k++) send(b + 64'(k), k == 0, 1'b0);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd5 || in_ready_o !== 1'b0) begin
      $display("FAIL wr1_ctrl: we=%b addr=%0d ready=%b want 1/5/0", mem_we_o, mem_addr_o, in_ready_o); n_bad++;
    end
    n_vec++;
    if (mem_wdata_o !== blk(b, 0, 7, 64'h7809)) begin
      $display("FAIL wr1_data: got %h want %h", mem_wdata_o, blk(b, 0, 7, 64'h7809)); n_bad++;
    end
    send(b + 64'd7, 1'b0, 1'b0);
    n_vec++;
    if (fl_alloc_req_o !== 1'b1) begin
      $display("FAIL req_after_wr1: req=%b want 1", fl_alloc_req_o); n_bad++;
    end
    fl_alloc_gnt_i = 1'b1; fl_alloc_idx_i = 10'd12;
    send(b + 64'd8, 1'b0, 1'b0);
    fl_alloc_gnt_i = 1'b0;
    for (int k = 9; k < 14; k++) send(b + 64'(k), 1'b0, k == 13);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd9 || mem_wdata_o !== blk(b, 7, 7, 64'h7C00)) begin
      $display("FAIL wr2: we=%b addr=%0d data=%h want addr 9 %h", mem_we_o, mem_addr_o, mem_wdata_o, blk(b, 7, 7, 64'h7C00)); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b1 || frm_head_idx_o !== 10'd5 || frm_cells_o !== 8'd2) begin
      $display("FAIL done1: done=%b head=%0d cells=%0d want 1/5/2", frm_done_o, frm_head_idx_o, frm_cells_o); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b0 || wr_cnt != 2 || done_cnt != 1 || err_cnt != 1) begin
      $display("FAIL counts1: done=%b wr=%0d dn=%0d err=%0d want 0/2/1/1", frm_done_o, wr_cnt, done_cnt, err_cnt); n_bad++;
    end
  endtask

  task automatic test_short_frame;
    logic [63:0] b;
    b = 64'hB200_0000_0000_0000;
    send(b, 1'b1, 1'b0);
    send(b + 64'd1, 1'b0, 1'b0);
    send(b + 64'd2, 1'b0, 1'b1);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd12 || mem_wdata_o !== blk(b, 0, 3, 64'h3C00)) begin
      $display("FAIL short_wr: we=%b addr=%0d data=%h want addr 12 %h", mem_we_o, mem_addr_o, mem_wdata_o, blk(b, 0, 3, 64'h3C00)); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b1 || frm_head_idx_o !== 10'd12 || frm_cells_o !== 8'd1 || wr_cnt != 3) begin
      $display("FAIL short_done: done=%b head=%0d cells=%0d wr=%0d want 1/12/1/3", frm_done_o, frm_head_idx_o, frm_cells_o, wr_cnt); n_bad++;
    end
  endtask

  task automatic test_stall;
    logic [63:0] b;
    b = 64'hC300_0000_0000_0000;
    send(b, 1'b1, 1'b0);
    send(b + 64'd1, 1'b0, 1'b1);
    repeat (3) begin
      n_vec++;
      if (in_ready_o !== 1'b0 || mem_we_o !== 1'b0) begin
        $display("FAIL stall_wait: ready=%b we=%b want 0/0", in_ready_o, mem_we_o); n_bad++;
      end
      @(negedge clk);
    end
    grant(10'd7);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd7 || mem_wdata_o !== blk(b, 0, 2, 64'h2C00)) begin
      $display("FAIL stall_wr: we=%b addr=%0d data=%h want addr 7 %h", mem_we_o, mem_addr_o, mem_wdata_o, blk(b, 0, 2, 64'h2C00)); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b1 || frm_head_idx_o !== 10'd7 || frm_cells_o !== 8'd1) begin
      $display("FAIL stall_done: done=%b head=%0d cells=%0d want 1/7/1", frm_done_o, frm_head_idx_o, frm_cells_o); n_bad++;
    end
  endtask

  task automatic test_no_sop;
    send(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    n_vec++;
    if (err_o !== 1'b1 || in_ready_o !== 1'b1) begin
      $display("FAIL nosop_err: err=%b ready=%b want 1/1", err_o, in_ready_o); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (err_o !== 1'b0 || in_ready_o !== 1'b1 || mem_we_o !== 1'b0 || wr_cnt != 4 || err_cnt != 2) begin
      $display("FAIL nosop_after: err=%b ready=%b we=%b wr=%0d errs=%0d want 0/1/0/4/2", err_o, in_ready_o, mem_we_o, wr_cnt, err_cnt); n_bad++;
    end
  endtask

  task automatic test_single_beat;
    logic [63:0] b;
    b = 64'hD500_0000_0000_0000;
    grant(10'd3);
    send(b, 1'b1, 1'b1);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd3 || mem_wdata_o !== blk(b, 0, 1, 64'h1C00)) begin
      $display("FAIL single_wr: we=%b addr=%0d data=%h want addr 3 %h", mem_we_o, mem_addr_o, mem_wdata_o, blk(b, 0, 1, 64'h1C00)); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b1 || frm_head_idx_o !== 10'd3 || frm_cells_o !== 8'd1) begin
      $display("FAIL single_done: done=%b head=%0d cells=%0d want 1/3/1", frm_done_o, frm_head_idx_o, frm_cells_o); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b0) begin
      $display("FAIL single_pulse: done=%b want 0", frm_done_o); n_bad++;
    end
  endtask

  task automatic test_reset_mid_cell;
    logic [63:0] b;
    b = 64'hE600_0000_0000_0000;
    grant(10'd20);
    grant(10'd21);
    for (int k = 0; k < 3; k++) send(64'hBAD0_0000_0000_0000 + 64'(k), k == 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({in_ready_o, fl_alloc_req_o, mem_we_o, frm_done_o, err_o} !== 5'b00000) begin
      $display("FAIL midrst_outs: got %b want 00000", {in_ready_o, fl_alloc_req_o, mem_we_o, frm_done_o, err_o}); n_bad++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({in_ready_o, fl_alloc_req_o} !== 2'b11) begin
      $display("FAIL midrst_release: ready/req=%b want 11", {in_ready_o, fl_alloc_req_o}); n_bad++;
    end
    grant(10'd30);
    grant(10'd31);
    for (int k = 0; k < 7; k++) send(b + 64'(k), k == 0, k == 6);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd30 || mem_wdata_o !== blk(b, 0, 7, 64'h7C00)) begin
      $display("FAIL midrst_wr: we=%b addr=%0d data=%h want addr 30 %h", mem_we_o, mem_addr_o, mem_wdata_o, blk(b, 0, 7, 64'h7C00)); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b1 || frm_head_idx_o !== 10'd30 || frm_cells_o !== 8'd1) begin
      $display("FAIL midrst_done: done=%b head=%0d cells=%0d want 1/30/1", frm_done_o, frm_head_idx_o, frm_cells_o); n_bad++;
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] b;
    b = 64'hF700_0000_0000_0000;
    send(b, 1'b1, 1'b1);
    n_vec++;
    if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd31 || mem_wdata_o !== blk(b, 0, 1, 64'h1C00)) begin
      $display("FAIL b2b_wr: we=%b addr=%0d data=%h want addr 31 %h", mem_we_o, mem_addr_o, mem_wdata_o, blk(b, 0, 1, 64'h1C00)); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (frm_done_o !== 1'b1 || frm_head_idx_o !== 10'd31) begin
      $display("FAIL b2b_done: done=%b head=%0d want 1/31", frm_done_o, frm_head_idx_o); n_bad++;
    end
    @(negedge clk);
    n_vec++;
    if (wr_cnt != 7 || done_cnt != 6 || err_cnt != 2) begin
      $display("FAIL totals: wr=%0d done=%0d err=%0d want 7/6/2", wr_cnt, done_cnt, err_cnt); n_bad++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data_i = '0; in_valid_i = 1'b0; in_sop_i = 1'b0; in_eop_i = 1'b0;
    fl_alloc_gnt_i = 1'b0; fl_alloc_idx_i = '0;
    @(negedge clk);
    test_reset();
    test_two_cell_frame();
    test_short_frame();
    test_stall();
    test_no_sop();
    test_single_beat();
    test_reset_mid_cell();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
